// File: rtl/dat_block_engine_if.sv
// Host, wrapper and FIFO signal bundle for dat_block_engine.
// Latency: none, this is wiring only.
// Backpressure: carried by fifo_empty/fifo_full and the ack_in/ack_out handshake.
// Ports: slave = engine side, master = host/wrapper/FIFO side.
interface dat_block_engine_if #(
    parameter int DATA_W = 32,
    parameter int BLK_W  = 8,
    parameter int TO_W   = 16
);
    // host -> engine
    logic              strobe_in;
    logic              ack_in;
    logic              idle_in;
    logic              write_read;
    logic              multiple;
    logic [BLK_W-1:0]  blocks;
    logic [TO_W-1:0]   timeout_reg;
    logic              wide_bus;
    // wrapper / FIFO -> engine
    logic              transmission_complete;
    logic              reception_complete;
    logic              crc_status_ok;
    logic [DATA_W-1:0] data_read;
    logic              fifo_empty;
    logic              fifo_full;
    // engine -> host
    logic              serial_ready;
    logic              complete;
    logic              ack_out;
    logic              data_timeout;
    logic              crc_error;
    logic [BLK_W-1:0]  blocks_done;
    // engine -> wrapper / pad / FIFO
    logic              reset_wrapper;
    logic              load_send;
    logic              enable_pts_wrapper;
    logic              enable_stp_wrapper;
    logic              waiting_response;
    logic              bus4_sel;
    logic              pad_state;
    logic              pad_enable;
    logic              write_fifo_enable;
    logic              read_fifo_enable;
    logic [DATA_W-1:0] data_to_fifo;

    modport slave (
        input  strobe_in, ack_in, idle_in, write_read, multiple, blocks,
               timeout_reg, wide_bus, transmission_complete, reception_complete,
               crc_status_ok, data_read, fifo_empty, fifo_full,
        output serial_ready, complete, ack_out, data_timeout, crc_error,
               blocks_done, reset_wrapper, load_send, enable_pts_wrapper,
               enable_stp_wrapper, waiting_response, bus4_sel, pad_state,
               pad_enable, write_fifo_enable, read_fifo_enable, data_to_fifo
    );

    modport master (
        output strobe_in, ack_in, idle_in, write_read, multiple, blocks,
               timeout_reg, wide_bus, transmission_complete, reception_complete,
               crc_status_ok, data_read, fifo_empty, fifo_full,
        input  serial_ready, complete, ack_out, data_timeout, crc_error,
               blocks_done, reset_wrapper, load_send, enable_pts_wrapper,
               enable_stp_wrapper, waiting_response, bus4_sel, pad_state,
               pad_enable, write_fifo_enable, read_fifo_enable, data_to_fifo
    );
endinterface

// File: rtl/dat_block_engine.sv
// SD data-line block sequencer: drives the serial wrappers, FIFO and pads for block read/write transfers.
// Latency: Moore outputs one sd_clock after the causing edge; FIFO enables are registered one-cycle pulses.
// Backpressure: stalls on fifo_empty (write) / fifo_full (read); completion held until ack_in.
// Ports: sd_clock, reset (async active-low); all host/wrapper/FIFO signals via dat_block_engine_if.slave.
module dat_block_engine #(
    parameter int DATA_W = 32,
    parameter int BLK_W  = 8,
    parameter int TO_W   = 16
) (
    input  logic              sd_clock,
    input  logic              reset,
    dat_block_engine_if.slave bus
);

    typedef enum logic [3:0] {
        S_RESET, S_IDLE, S_LOAD_WRITE, S_SEND, S_WAIT_RESPONSE, S_READ,
        S_READ_FIFO_WRITE, S_READ_WRAPPER_RESET, S_WAIT_ACK, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic              bus4_q, bus4_d;
    logic [TO_W-1:0]   to_reg_q, to_reg_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [BLK_W-1:0]  target_q, target_d;
    logic [BLK_W-1:0]  done_q, done_d;
    logic              crc_err_q, crc_err_d;
    logic              to_err_q, to_err_d;
    logic              wr_fifo_en_q, wr_fifo_en_d;
    logic              rd_fifo_en_q, rd_fifo_en_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    logic [TO_W-1:0]   to_cnt_inc;
    logic              timed_out;
    logic [BLK_W-1:0]  done_inc;
    logic              last_blk;

    // Counter saturates at the captured limit; reaching the limit is the timeout.
    assign to_cnt_inc = (to_cnt_q == to_reg_q) ? to_cnt_q : to_cnt_q + TO_W'(1);
    assign timed_out  = (to_cnt_inc == to_reg_q);
    // Once at target the count holds, so it can never pass target or wrap.
    assign done_inc   = (done_q == target_q) ? done_q : done_q + BLK_W'(1);
    assign last_blk   = (done_inc == target_q);

    always_comb begin
        state_d      = state_q;
        bus4_d       = bus4_q;
        to_reg_d     = to_reg_q;
        to_cnt_d     = to_cnt_q;
        target_d     = target_q;
        done_d       = done_q;
        crc_err_d    = crc_err_q;
        to_err_d     = to_err_q;
        wr_fifo_en_d = 1'b0;
        rd_fifo_en_d = 1'b0;
        dat_d        = dat_q;
        // Abort wins over everything; flags and block count are left as they are.
        if (bus.idle_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_RESET: state_d = S_IDLE;
                S_IDLE: begin
                    if (bus.strobe_in) begin
                        bus4_d    = bus.wide_bus;
                        to_reg_d  = bus.timeout_reg;
                        target_d  = (!bus.multiple || bus.blocks == '0) ? BLK_W'(1) : bus.blocks;
                        done_d    = '0;
                        crc_err_d = 1'b0;
                        to_err_d  = 1'b0;
                        to_cnt_d  = '0;
                        state_d   = bus.write_read ? S_LOAD_WRITE : S_READ;
                    end
                end
                S_LOAD_WRITE: begin
                    if (!bus.fifo_empty) begin
                        wr_fifo_en_d = 1'b1;
                        state_d      = S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.transmission_complete) begin
                        to_cnt_d = '0;
                        state_d  = S_WAIT_RESPONSE;
                    end
                end
                S_WAIT_RESPONSE: begin
                    // A response arriving on the timeout cycle is still honoured.
                    if (bus.reception_complete) begin
                        if (!bus.crc_status_ok) begin
                            crc_err_d = 1'b1;
                            state_d   = S_ERROR;
                        end else begin
                            done_d  = done_inc;
                            state_d = last_blk ? S_WAIT_ACK : S_LOAD_WRITE;
                        end
                    end else if (timed_out) begin
                        to_err_d = 1'b1;
                        state_d  = S_ERROR;
                    end else begin
                        to_cnt_d = to_cnt_inc;
                    end
                end
                S_READ: begin
                    if (bus.reception_complete) begin
                        state_d = S_READ_FIFO_WRITE;
                    end else if (timed_out) begin
                        to_err_d = 1'b1;
                        state_d  = S_ERROR;
                    end else begin
                        to_cnt_d = to_cnt_inc;
                    end
                end
                S_READ_FIFO_WRITE: begin
                    if (!bus.fifo_full) begin
                        rd_fifo_en_d = 1'b1;
                        dat_d        = bus.data_read;
                        done_d       = done_inc;
                        state_d      = last_blk ? S_WAIT_ACK : S_READ_WRAPPER_RESET;
                    end
                end
                S_READ_WRAPPER_RESET: begin
                    to_cnt_d = '0;
                    state_d  = S_READ;
                end
                S_WAIT_ACK, S_ERROR: begin
                    if (bus.ack_in) state_d = S_IDLE;
                end
                default: state_d = S_RESET;
            endcase
        end
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RESET;
            bus4_q       <= 1'b0;
            to_reg_q     <= '0;
            to_cnt_q     <= '0;
            target_q     <= '0;
            done_q       <= '0;
            crc_err_q    <= 1'b0;
            to_err_q     <= 1'b0;
            wr_fifo_en_q <= 1'b0;
            rd_fifo_en_q <= 1'b0;
            dat_q        <= '0;
        end else begin
            state_q      <= state_d;
            bus4_q       <= bus4_d;
            to_reg_q     <= to_reg_d;
            to_cnt_q     <= to_cnt_d;
            target_q     <= target_d;
            done_q       <= done_d;
            crc_err_q    <= crc_err_d;
            to_err_q     <= to_err_d;
            wr_fifo_en_q <= wr_fifo_en_d;
            rd_fifo_en_q <= rd_fifo_en_d;
            dat_q        <= dat_d;
        end
    end

    // Everything decoded from registered state; ack_out alone passes ack_in straight through.
    assign bus.serial_ready       = (state_q == S_IDLE);
    assign bus.complete           = (state_q == S_WAIT_ACK) || (state_q == S_ERROR);
    assign bus.ack_out            = bus.complete && bus.ack_in;
    assign bus.reset_wrapper      = (state_q == S_RESET) || (state_q == S_IDLE) ||
                                    (state_q == S_READ_WRAPPER_RESET) || bus.complete;
    assign bus.load_send          = (state_q == S_SEND);
    assign bus.enable_pts_wrapper = (state_q == S_LOAD_WRITE) || (state_q == S_SEND);
    assign bus.pad_state          = bus.enable_pts_wrapper;
    assign bus.enable_stp_wrapper = (state_q == S_READ);
    assign bus.waiting_response   = (state_q == S_WAIT_RESPONSE);
    assign bus.pad_enable         = bus.enable_pts_wrapper || bus.waiting_response ||
                                    (state_q == S_READ) || (state_q == S_READ_FIFO_WRITE) ||
                                    (state_q == S_READ_WRAPPER_RESET);
    assign bus.bus4_sel           = bus4_q;
    assign bus.write_fifo_enable  = wr_fifo_en_q;
    assign bus.read_fifo_enable   = rd_fifo_en_q;
    assign bus.data_to_fifo       = dat_q;
    assign bus.blocks_done        = done_q;
    assign bus.data_timeout       = to_err_q;
    assign bus.crc_error          = crc_err_q;

endmodule

// File: tb/tb_dat_block_engine.sv
// Directed bench for dat_block_engine: write, multi-read with FIFO stall, timeouts, CRC error, abort, reset.
module tb_dat_block_engine;

    logic sd_clock = 1'b0;
    logic reset    = 1'b1;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   rd_pulses  = 0;
    int   rst_cycles = 0;
    logic mon_en     = 1'b0;

    dat_block_engine_if #(.DATA_W(32), .BLK_W(8), .TO_W(16)) ifc ();

    dat_block_engine #(.DATA_W(32), .BLK_W(8), .TO_W(16)) dut (
        .sd_clock (sd_clock),
        .reset    (reset),
        .bus      (ifc)
    );

    always #5 sd_clock = ~sd_clock;

    always @(negedge sd_clock) begin
        if (mon_en) begin
            if (ifc.read_fifo_enable) rd_pulses++;
            if (ifc.reset_wrapper && !ifc.serial_ready && !ifc.complete) rst_cycles++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge sd_clock);
        #1;
    endtask

    task automatic start_xfer(input logic wr, input logic mult, input logic [7:0] blks,
                              input logic wide, input logic [15:0] to);
        ifc.write_read  = wr;
        ifc.multiple    = mult;
        ifc.blocks      = blks;
        ifc.wide_bus    = wide;
        ifc.timeout_reg = to;
        ifc.strobe_in   = 1'b1;
        tick();
        ifc.strobe_in   = 1'b0;
    endtask

    task automatic do_ack;
        ifc.ack_in = 1'b1;
        tick();
        ifc.ack_in = 1'b0;
    endtask

    function automatic logic [14:0] out_vec;
        return {ifc.serial_ready, ifc.complete, ifc.ack_out, ifc.data_timeout, ifc.crc_error,
                ifc.reset_wrapper, ifc.load_send, ifc.enable_pts_wrapper, ifc.enable_stp_wrapper,
                ifc.waiting_response, ifc.bus4_sel, ifc.pad_state, ifc.pad_enable,
                ifc.write_fifo_enable, ifc.read_fifo_enable};
    endfunction

    task automatic test_reset;
        ifc.strobe_in = 0; ifc.ack_in = 0; ifc.idle_in = 0; ifc.write_read = 0;
        ifc.multiple = 0; ifc.blocks = 0; ifc.timeout_reg = 0; ifc.wide_bus = 0;
        ifc.transmission_complete = 0; ifc.reception_complete = 0; ifc.crc_status_ok = 0;
        ifc.data_read = 0; ifc.fifo_empty = 1; ifc.fifo_full = 0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (out_vec() !== 15'b000001000000000) begin
            n_bad++; $display("FAIL reset_outputs: got %b want %b", out_vec(), 15'b000001000000000);
        end
        n_cmp++;
        if (ifc.blocks_done !== 8'd0 || ifc.data_to_fifo !== 32'd0) begin
            n_bad++; $display("FAIL reset_counters: blocks_done=%0d data_to_fifo=%h want 0/0",
                              ifc.blocks_done, ifc.data_to_fifo);
        end
        tick(); tick();
        n_cmp++;
        if (ifc.serial_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_hold: serial_ready=%b want 0", ifc.serial_ready);
        end
        @(negedge sd_clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ifc.serial_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_sync: serial_ready=%b want 0", ifc.serial_ready);
        end
        tick();
        n_cmp++;
        if (ifc.serial_ready !== 1'b1 || ifc.reset_wrapper !== 1'b1) begin
            n_bad++; $display("FAIL idle_after_reset: serial_ready=%b reset_wrapper=%b want 1/1",
                              ifc.serial_ready, ifc.reset_wrapper);
        end
    endtask

    task automatic test_single_write;
        ifc.fifo_empty = 1'b1;
        start_xfer(1'b1, 1'b0, 8'd5, 1'b1, 16'd50);
        // serial_ready, pad_state, pad_enable, enable_pts, load_send, write_fifo_enable
        n_cmp++;
        if ({ifc.serial_ready, ifc.pad_state, ifc.pad_enable, ifc.enable_pts_wrapper,
             ifc.load_send, ifc.write_fifo_enable, ifc.bus4_sel} !== 7'b0111001) begin
            n_bad++; $display("FAIL wr_load_state: got %b want 0111001",
                {ifc.serial_ready, ifc.pad_state, ifc.pad_enable, ifc.enable_pts_wrapper,
                 ifc.load_send, ifc.write_fifo_enable, ifc.bus4_sel});
        end
        tick();
        n_cmp++;
        if (ifc.load_send !== 1'b0 || ifc.write_fifo_enable !== 1'b0 || ifc.pad_state !== 1'b1) begin
            n_bad++; $display("FAIL wr_empty_stall: load_send=%b wfe=%b pad_state=%b want 0/0/1",
                              ifc.load_send, ifc.write_fifo_enable, ifc.pad_state);
        end
        ifc.fifo_empty = 1'b0;
        tick();
        ifc.fifo_empty = 1'b1;
        n_cmp++;
        if ({ifc.load_send, ifc.write_fifo_enable} !== 2'b11) begin
            n_bad++; $display("FAIL wr_send_entry: load_send,wfe=%b want 11",
                              {ifc.load_send, ifc.write_fifo_enable});
        end
        tick();
        n_cmp++;
        if ({ifc.load_send, ifc.write_fifo_enable} !== 2'b10) begin
            n_bad++; $display("FAIL wr_fifo_pulse_width: load_send,wfe=%b want 10",
                              {ifc.load_send, ifc.write_fifo_enable});
        end
        ifc.transmission_complete = 1'b1;
        tick();
        ifc.transmission_complete = 1'b0;
        n_cmp++;
        if ({ifc.waiting_response, ifc.pad_enable, ifc.pad_state, ifc.load_send} !== 4'b1100) begin
            n_bad++; $display("FAIL wr_wait_response: got %b want 1100",
                {ifc.waiting_response, ifc.pad_enable, ifc.pad_state, ifc.load_send});
        end
        tick(); tick();
        ifc.reception_complete = 1'b1;
        ifc.crc_status_ok      = 1'b1;
        tick();
        ifc.reception_complete = 1'b0;
        n_cmp++;
        if ({ifc.complete, ifc.crc_error, ifc.reset_wrapper, ifc.waiting_response} !== 4'b1010 ||
            ifc.blocks_done !== 8'd1) begin
            n_bad++; $display("FAIL wr_done: cplt,crc,rstw,wait=%b blocks_done=%0d want 1010/1",
                {ifc.complete, ifc.crc_error, ifc.reset_wrapper, ifc.waiting_response}, ifc.blocks_done);
        end
        ifc.ack_in = 1'b1;
        #1;
        n_cmp++;
        if (ifc.ack_out !== 1'b1) begin
            n_bad++; $display("FAIL wr_ack_out: ack_out=%b want 1", ifc.ack_out);
        end
        tick();
        n_cmp++;
        if (ifc.serial_ready !== 1'b1 || ifc.ack_out !== 1'b0 || ifc.blocks_done !== 8'd1) begin
            n_bad++; $display("FAIL wr_back_idle: ready=%b ack_out=%b blocks_done=%0d want 1/0/1",
                              ifc.serial_ready, ifc.ack_out, ifc.blocks_done);
        end
        ifc.ack_in = 1'b0;
    endtask

    task automatic test_multi_read;
        int n;
        ifc.fifo_full = 1'b0;
        rd_pulses = 0; rst_cycles = 0; mon_en = 1'b1;
        start_xfer(1'b0, 1'b1, 8'd3, 1'b0, 16'd100);
        n_cmp++;
        if (ifc.blocks_done !== 8'd0 || ifc.enable_stp_wrapper !== 1'b1) begin
            n_bad++; $display("FAIL rd_start: blocks_done=%0d stp=%b want 0/1",
                              ifc.blocks_done, ifc.enable_stp_wrapper);
        end
        for (int b = 1; b <= 3; b++) begin
            tick(); tick();
            ifc.data_read          = 32'hA5A0_0000 + b;
            ifc.reception_complete = 1'b1;
            ifc.fifo_full          = (b == 2);
            tick();
            ifc.reception_complete = 1'b0;
            n = 0;
            while (!ifc.read_fifo_enable && n < 10) begin
                if (b == 2 && n == 2) ifc.fifo_full = 1'b0;
                tick();
                n++;
            end
            n_cmp++;
            if (n !== ((b == 2) ? 3 : 1)) begin
                n_bad++; $display("FAIL rd_fifo_latency_blk%0d: cycles=%0d want %0d", b, n, (b == 2) ? 3 : 1);
            end
            n_cmp++;
            if (ifc.data_to_fifo !== 32'hA5A0_0000 + b || ifc.blocks_done !== b[7:0]) begin
                n_bad++; $display("FAIL rd_data_blk%0d: data=%h done=%0d want %h/%0d",
                                  b, ifc.data_to_fifo, ifc.blocks_done, 32'hA5A0_0000 + b, b);
            end
            if (b < 3) begin
                n_cmp++;
                if (ifc.reset_wrapper !== 1'b1 || ifc.enable_stp_wrapper !== 1'b0) begin
                    n_bad++; $display("FAIL rd_wrapper_reset_blk%0d: rstw=%b stp=%b want 1/0",
                                      b, ifc.reset_wrapper, ifc.enable_stp_wrapper);
                end
                tick();
                n_cmp++;
                if (ifc.reset_wrapper !== 1'b0 || ifc.enable_stp_wrapper !== 1'b1) begin
                    n_bad++; $display("FAIL rd_reread_blk%0d: rstw=%b stp=%b want 0/1",
                                      b, ifc.reset_wrapper, ifc.enable_stp_wrapper);
                end
            end else begin
                n_cmp++;
                if (ifc.complete !== 1'b1) begin
                    n_bad++; $display("FAIL rd_complete: complete=%b want 1", ifc.complete);
                end
            end
        end
        @(negedge sd_clock);
        #1 mon_en = 1'b0;
        n_cmp++;
        if (rd_pulses !== 3 || rst_cycles !== 2 || ifc.blocks_done !== 8'd3) begin
            n_bad++; $display("FAIL rd_totals: rd_pulses=%0d rst_cycles=%0d done=%0d want 3/2/3",
                              rd_pulses, rst_cycles, ifc.blocks_done);
        end
        do_ack();
    endtask

    task automatic test_read_timeout;
        int cnt;
        start_xfer(1'b0, 1'b0, 8'd1, 1'b0, 16'd10);
        cnt = 0;
        while (ifc.enable_stp_wrapper && cnt < 40) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 10) begin
            n_bad++; $display("FAIL to_cycles_in_read: got %0d want 10", cnt);
        end
        n_cmp++;
        if ({ifc.data_timeout, ifc.complete, ifc.pad_enable, ifc.reset_wrapper, ifc.crc_error} !== 5'b11010) begin
            n_bad++; $display("FAIL to_error_state: got %b want 11010",
                {ifc.data_timeout, ifc.complete, ifc.pad_enable, ifc.reset_wrapper, ifc.crc_error});
        end
        ifc.ack_in = 1'b1;
        #1;
        n_cmp++;
        if (ifc.ack_out !== 1'b1) begin
            n_bad++; $display("FAIL to_ack_out: ack_out=%b want 1", ifc.ack_out);
        end
        tick();
        ifc.ack_in = 1'b0;
        n_cmp++;
        if (ifc.serial_ready !== 1'b1 || ifc.data_timeout !== 1'b1) begin
            n_bad++; $display("FAIL to_sticky: ready=%b data_timeout=%b want 1/1",
                              ifc.serial_ready, ifc.data_timeout);
        end
    endtask

    task automatic test_rc_beats_timeout;
        ifc.fifo_full = 1'b0;
        ifc.data_read = 32'h1234_5678;
        start_xfer(1'b0, 1'b1, 8'd0, 1'b0, 16'd3);
        n_cmp++;
        if (ifc.data_timeout !== 1'b0) begin
            n_bad++; $display("FAIL tie_flag_cleared: data_timeout=%b want 0", ifc.data_timeout);
        end
        tick(); tick();
        ifc.reception_complete = 1'b1;
        tick();
        ifc.reception_complete = 1'b0;
        n_cmp++;
        if ({ifc.data_timeout, ifc.complete, ifc.enable_stp_wrapper} !== 3'b000) begin
            n_bad++; $display("FAIL tie_rc_wins: to,cplt,stp=%b want 000",
                {ifc.data_timeout, ifc.complete, ifc.enable_stp_wrapper});
        end
        tick();
        n_cmp++;
        if (ifc.complete !== 1'b1 || ifc.blocks_done !== 8'd1 || ifc.read_fifo_enable !== 1'b1 ||
            ifc.data_to_fifo !== 32'h1234_5678) begin
            n_bad++; $display("FAIL tie_zero_blocks_one_target: cplt=%b done=%0d rfe=%b data=%h want 1/1/1/12345678",
                ifc.complete, ifc.blocks_done, ifc.read_fifo_enable, ifc.data_to_fifo);
        end
        do_ack();
    endtask

    task automatic test_multi_write_crc;
        ifc.fifo_empty = 1'b0;
        start_xfer(1'b1, 1'b1, 8'd4, 1'b0, 16'd50);
        n_cmp++;
        if (ifc.blocks_done !== 8'd0) begin
            n_bad++; $display("FAIL crc_count_cleared: blocks_done=%0d want 0", ifc.blocks_done);
        end
        for (int b = 1; b <= 2; b++) begin
            tick();
            ifc.transmission_complete = 1'b1;
            tick();
            ifc.transmission_complete = 1'b0;
            ifc.reception_complete    = 1'b1;
            ifc.crc_status_ok         = (b == 1);
            tick();
            ifc.reception_complete    = 1'b0;
            if (b == 1) begin
                n_cmp++;
                if (ifc.pad_state !== 1'b1 || ifc.waiting_response !== 1'b0 || ifc.blocks_done !== 8'd1) begin
                    n_bad++; $display("FAIL crc_blk1_next: pad_state=%b wait=%b done=%0d want 1/0/1",
                                      ifc.pad_state, ifc.waiting_response, ifc.blocks_done);
                end
            end else begin
                n_cmp++;
                if ({ifc.crc_error, ifc.complete, ifc.pad_enable, ifc.data_timeout} !== 4'b1100 ||
                    ifc.blocks_done !== 8'd1) begin
                    n_bad++; $display("FAIL crc_error_state: crc,cplt,pad_en,to=%b done=%0d want 1100/1",
                        {ifc.crc_error, ifc.complete, ifc.pad_enable, ifc.data_timeout}, ifc.blocks_done);
                end
            end
        end
        do_ack();
        ifc.fifo_empty = 1'b1;
    endtask

    task automatic test_idle_abort;
        ifc.fifo_empty    = 1'b0;
        ifc.crc_status_ok = 1'b1;
        start_xfer(1'b1, 1'b1, 8'd2, 1'b1, 16'd50);
        tick();
        ifc.transmission_complete = 1'b1;
        tick();
        ifc.transmission_complete = 1'b0;
        ifc.reception_complete    = 1'b1;
        tick();
        ifc.reception_complete    = 1'b0;
        tick();
        n_cmp++;
        if (ifc.load_send !== 1'b1 || ifc.crc_error !== 1'b0) begin
            n_bad++; $display("FAIL abort_in_send: load_send=%b crc=%b want 1/0", ifc.load_send, ifc.crc_error);
        end
        ifc.idle_in = 1'b1;
        tick();
        ifc.idle_in = 1'b0;
        n_cmp++;
        if (ifc.serial_ready !== 1'b1 || ifc.load_send !== 1'b0 || ifc.blocks_done !== 8'd1) begin
            n_bad++; $display("FAIL abort_to_idle: ready=%b load_send=%b done=%0d want 1/0/1",
                              ifc.serial_ready, ifc.load_send, ifc.blocks_done);
        end
        ifc.fifo_empty = 1'b1;
    endtask

    task automatic test_reset_mid_read;
        ifc.fifo_full = 1'b0;
        ifc.data_read = 32'hDEAD_BEEF;
        start_xfer(1'b0, 1'b1, 8'd2, 1'b1, 16'd100);
        tick();
        ifc.reception_complete = 1'b1;
        tick();
        ifc.reception_complete = 1'b0;
        tick(); tick();
        n_cmp++;
        if (ifc.enable_stp_wrapper !== 1'b1 || ifc.blocks_done !== 8'd1 || ifc.bus4_sel !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_read: stp=%b done=%0d bus4=%b want 1/1/1",
                              ifc.enable_stp_wrapper, ifc.blocks_done, ifc.bus4_sel);
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (out_vec() !== 15'b000001000000000 || ifc.blocks_done !== 8'd0 || ifc.data_to_fifo !== 32'd0) begin
            n_bad++; $display("FAIL rst_mid_read: outs=%b done=%0d data=%h want 000001000000000/0/0",
                              out_vec(), ifc.blocks_done, ifc.data_to_fifo);
        end
        @(negedge sd_clock);
        reset = 1'b1;
        tick();
        n_cmp++;
        if (ifc.serial_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_recover_idle: ready=%b want 1", ifc.serial_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_read();
        test_read_timeout();
        test_rc_beats_timeout();
        test_multi_write_crc();
        test_idle_abort();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dat_block_engine.md
DAT_BLOCK_ENGINE -- requirements
Module: dat_block_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width to/from the FIFO.
REQ-002 SHALL have parameter BLK_W, default 8, meaning block-count width.
REQ-003 SHALL have parameter TO_W, default 16, meaning timeout-counter width.
REQ-004 SHALL have port sd_clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have these host inputs: strobe_in 1 (start request); ack_in 1 (host accepts completion); idle_in 1 (abort); write_read 1 (1=write); multiple 1; blocks BLK_W; timeout_reg TO_W; wide_bus 1 (4-bit bus mode).
REQ-007 SHALL have these wrapper/FIFO inputs: transmission_complete 1; reception_complete 1; crc_status_ok 1 (valid with reception_complete in write flow); data_read DATA_W; fifo_empty 1; fifo_full 1.
REQ-008 SHALL have these host outputs: serial_ready 1; complete 1; ack_out 1; data_timeout 1; crc_error 1; blocks_done BLK_W.
REQ-009 SHALL have these wrapper/pad/FIFO outputs: reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper, waiting_response, bus4_sel, pad_state, pad_enable, write_fifo_enable, read_fifo_enable, each 1; data_to_fifo DATA_W.

Function
REQ-010 SHALL implement states RESET, IDLE, LOAD_WRITE, SEND, WAIT_RESPONSE, READ, READ_FIFO_WRITE, READ_WRAPPER_RESET, WAIT_ACK, ERROR; all outputs decoded from registered state only (Moore), except ack_out.
REQ-011 RESET -> IDLE unconditionally. In IDLE: serial_ready=1, reset_wrapper=1; on strobe_in capture write_read, multiple, blocks, wide_bus, timeout_reg, then go to LOAD_WRITE (write) or READ (read).
REQ-012 Target count = 1 if multiple=0 or captured blocks=0, else captured blocks.
REQ-013 LOAD_WRITE: stall while fifo_empty=1; else pulse write_fifo_enable for one cycle, go to SEND. pad_state=1, pad_enable=1, enable_pts_wrapper=1.
REQ-014 SEND: load_send=1, enable_pts_wrapper=1, pad_state=1, pad_enable=1; on transmission_complete go to WAIT_RESPONSE.
REQ-015 WAIT_RESPONSE: waiting_response=1, pad_enable=1, pad_state=0; on reception_complete with crc_status_ok=0 go to ERROR and set crc_error; with crc_status_ok=1 increment blocks_done and go to WAIT_ACK if new count = target, else LOAD_WRITE.
REQ-016 READ: enable_stp_wrapper=1, pad_enable=1, pad_state=0; on reception_complete go to READ_FIFO_WRITE.
REQ-017 READ_FIFO_WRITE: stall while fifo_full=1; else read_fifo_enable=1 for one cycle, data_to_fifo=data_read, increment blocks_done, then WAIT_ACK if count = target, else READ_WRAPPER_RESET.
REQ-018 READ_WRAPPER_RESET: reset_wrapper=1 for exactly one cycle, then READ.
REQ-019 Timeout counter SHALL count sd_clock cycles in WAIT_RESPONSE and READ, clear on entry to either state, saturate at timeout_reg; reaching it goes to ERROR and sets data_timeout.
REQ-020 WAIT_ACK: complete=1, reset_wrapper=1; ERROR: complete=1, reset_wrapper=1, pad_enable=0; in both, ack_out=ack_in combinationally, and ack_in returns to IDLE.
REQ-021 data_timeout and crc_error SHALL be sticky until the next accepted strobe_in; blocks_done SHALL clear on accepted strobe_in and hold thereafter.
REQ-022 bus4_sel SHALL equal wide_bus captured at strobe_in, held for the whole transfer.
REQ-023 idle_in=1 SHALL force IDLE on the next edge from any state, overriding all other transitions; flags and blocks_done are held.
REQ-024 If reception_complete and the timeout coincide in one cycle, reception_complete SHALL win.
REQ-025 blocks_done SHALL never exceed target; no wrap at 2^BLK_W-1.

Reset
REQ-026 reset=0 SHALL asynchronously force state RESET, all outputs 0 except reset_wrapper=1, and all counters, flags and captured fields to 0.
REQ-027 Deasserting reset SHALL take effect synchronously at the next sd_clock edge; RESET -> IDLE one cycle later.

Verification
REQ-028 Single write with crc_status_ok=1: strobe_in, write_read=1 -> LOAD_WRITE, SEND, WAIT_RESPONSE, WAIT_ACK; complete=1, blocks_done=1, crc_error=0.
REQ-029 Multi-read with blocks=3 and fifo_full high 2 cycles on block 2 -> three read_fifo_enable pulses, two one-cycle reset_wrapper pulses, blocks_done=3, read stalls 2 cycles.
REQ-030 Read with timeout_reg=10 and no reception_complete -> ERROR after 10 cycles in READ, data_timeout=1, complete=1; ack_in returns to IDLE.
REQ-031 Multi-write with blocks=4 and crc_status_ok=0 on block 2 -> ERROR, crc_error=1, blocks_done=1.
REQ-032 idle_in mid-SEND, and reset=0 mid-READ -> IDLE next edge; immediate RESET with outputs at reset values.
